// File: rtl/mfe_lcd1602_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mfe_lcd1602_responder : HD44780-style device end of an 8-bit LCD1602 bus
// Rev 1.0 - DDRAM image, AC/flags, busy-time model, status/data reads
// ---------------------------------------------------------------------------
module mfe_lcd1602_responder #(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_i,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [5:0] shift_ofs,
  output logic       cmd_vld,
  output logic [8:0] cmd_code,
  output logic       overrun,
  output logic       addr_err,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam logic [31:0] BUSY_LD = 32'(BUSY_CYCLES - 1);
  localparam logic [31:0] CLR_LD  = 32'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_EXEC    = 3'd2,
    ST_CLRFILL = 3'd3,
    ST_BUSY    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        en_s1_q, en_s2_q, en_s3_q;
  logic        bus_rs_q, bus_rw_q;
  logic [7:0]  bus_data_q;
  logic        smp_rs_q, smp_rs_d, smp_rw_q, smp_rw_d;
  logic [7:0]  smp_data_q, smp_data_d;
  logic [6:0]  ac_q, ac_d;
  logic        id_q, id_d, s_q, s_d, d_q, d_d, c_q, c_d, b_q, b_d;
  logic        cg_q, cg_d, clr_q, clr_d;
  logic [5:0]  ofs_q, ofs_d;
  logic [6:0]  fill_q, fill_d;
  logic [31:0] cnt_q, cnt_d;
  logic        vld_q, vld_d, ovr_q, ovr_d, aerr_q, aerr_d, oe_q, oe_d;
  logic [8:0]  code_q, code_d;
  logic [7:0]  rdat_q, rdat_d, dbg_q, dbg_d;
  logic [7:0]  mem_q [80];
  logic        mem_we;
  logic [6:0]  mem_wa;
  logic [7:0]  mem_wd;
  logic        fall, busy_w;
  logic [6:0]  idx;

  // AC walks line 0 then line 1 as one 80-position ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
  endfunction

  function automatic logic [5:0] ofs_step(input logic [5:0] o, input logic inc);
    if (inc) return (o == 6'd39) ? 6'd0 : o + 6'd1;
    else     return (o == 6'd0) ? 6'd39 : o - 6'd1;
  endfunction

  always_comb begin
    fall       = en_s3_q & ~en_s2_q;
    busy_w     = (state_q != ST_IDLE);
    idx        = (ac_q[6] ? 7'd40 : 7'd0) + {1'b0, ac_q[5:0]};
    state_d    = state_q;
    smp_rs_d   = smp_rs_q;
    smp_rw_d   = smp_rw_q;
    smp_data_d = smp_data_q;
    ac_d       = ac_q;
    id_d       = id_q;
    s_d        = s_q;
    d_d        = d_q;
    c_d        = c_q;
    b_d        = b_q;
    cg_d       = cg_q;
    clr_d      = clr_q;
    ofs_d      = ofs_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    vld_d      = 1'b0;
    code_d     = code_q;
    ovr_d      = ovr_q;
    aerr_d     = aerr_q;
    mem_we     = 1'b0;
    mem_wa     = fill_q;
    mem_wd     = 8'h20;

    if (en_s1_q) begin
      smp_rs_d   = bus_rs_q;
      smp_rw_d   = bus_rw_q;
      smp_data_d = bus_data_q;
    end

    case (state_q)
      ST_INIT, ST_CLRFILL: begin
        mem_we = 1'b1;
        fill_d = fill_q + 7'd1;
        if (state_q == ST_CLRFILL) cnt_d = cnt_q - 32'd1;
        if (fill_q == 7'd79) begin
          fill_d  = 7'd0;
          state_d = (state_q == ST_INIT) ? ST_IDLE : ST_BUSY;
        end
      end
      ST_EXEC: begin
        cnt_d   = cnt_q - 32'd1;
        state_d = clr_q ? ST_CLRFILL : ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt_q == 32'd0) state_d = ST_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: ;
    endcase

    if (fall) begin
      if (smp_rw_q) begin
        vld_d  = 1'b1;
        code_d = {smp_rs_q, smp_data_q};
        if (smp_rs_q && !cg_q) ac_d = ac_step(ac_q, id_q);
      end else if (busy_w) begin
        ovr_d = 1'b1;
      end else begin
        vld_d   = 1'b1;
        code_d  = {smp_rs_q, smp_data_q};
        state_d = ST_EXEC;
        cnt_d   = BUSY_LD;
        clr_d   = 1'b0;
        if (smp_rs_q) begin
          if (!cg_q) begin
            mem_we = 1'b1;
            mem_wa = idx;
            mem_wd = smp_data_q;
            ac_d   = ac_step(ac_q, id_q);
            if (s_q) ofs_d = ofs_step(ofs_q, id_q);
          end
        end else begin
          // DL/N/F of function set have no observable effect on this model.
          casez (smp_data_q)
            8'b1???????: begin
              cg_d = 1'b0;
              if (smp_data_q[5:0] < 6'd40) ac_d = smp_data_q[6:0];
              else begin
                ac_d   = 7'h00;
                aerr_d = 1'b1;
              end
            end
            8'b01??????: cg_d = 1'b1;
            8'b0001????: begin
              if (smp_data_q[3]) ofs_d = ofs_step(ofs_q, smp_data_q[2]);
              else               ac_d  = ac_step(ac_q, smp_data_q[2]);
            end
            8'b00001???: {d_d, c_d, b_d} = smp_data_q[2:0];
            8'b000001??: {id_d, s_d} = smp_data_q[1:0];
            8'b0000001?: begin
              ac_d  = 7'h00;
              ofs_d = 6'd0;
              cg_d  = 1'b0;
              cnt_d = CLR_LD;
            end
            8'b00000001: begin
              ac_d  = 7'h00;
              ofs_d = 6'd0;
              id_d  = 1'b1;
              cg_d  = 1'b0;
              clr_d = 1'b1;
              cnt_d = CLR_LD;
            end
            default: ;
          endcase
        end
      end
    end

    oe_d   = en_s2_q & smp_rw_q;
    rdat_d = 8'h00;
    if (oe_d) rdat_d = smp_rs_q ? mem_q[idx] : {busy_w, ac_q};
    dbg_d  = (dbg_addr < 7'd80) ? mem_q[dbg_addr] : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      en_s1_q    <= 1'b0;
      en_s2_q    <= 1'b0;
      en_s3_q    <= 1'b0;
      bus_rs_q   <= 1'b0;
      bus_rw_q   <= 1'b0;
      bus_data_q <= 8'h00;
      smp_rs_q   <= 1'b0;
      smp_rw_q   <= 1'b0;
      smp_data_q <= 8'h00;
      ac_q       <= 7'h00;
      id_q       <= 1'b1;
      s_q        <= 1'b0;
      d_q        <= 1'b0;
      c_q        <= 1'b0;
      b_q        <= 1'b0;
      cg_q       <= 1'b0;
      clr_q      <= 1'b0;
      ofs_q      <= 6'd0;
      fill_q     <= 7'd0;
      cnt_q      <= 32'd0;
      vld_q      <= 1'b0;
      code_q     <= 9'd0;
      ovr_q      <= 1'b0;
      aerr_q     <= 1'b0;
      oe_q       <= 1'b0;
      rdat_q     <= 8'h00;
      dbg_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      en_s1_q    <= lcd_en;
      en_s2_q    <= en_s1_q;
      en_s3_q    <= en_s2_q;
      bus_rs_q   <= lcd_rs;
      bus_rw_q   <= lcd_rw;
      bus_data_q <= lcd_data_i;
      smp_rs_q   <= smp_rs_d;
      smp_rw_q   <= smp_rw_d;
      smp_data_q <= smp_data_d;
      ac_q       <= ac_d;
      id_q       <= id_d;
      s_q        <= s_d;
      d_q        <= d_d;
      c_q        <= c_d;
      b_q        <= b_d;
      cg_q       <= cg_d;
      clr_q      <= clr_d;
      ofs_q      <= ofs_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      vld_q      <= vld_d;
      code_q     <= code_d;
      ovr_q      <= ovr_d;
      aerr_q     <= aerr_d;
      oe_q       <= oe_d;
      rdat_q     <= rdat_d;
      dbg_q      <= dbg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign lcd_data_o  = rdat_q;
  assign lcd_data_oe = oe_q;
  assign busy        = busy_w;
  assign ac          = ac_q;
  assign disp_on     = d_q;
  assign cursor_on   = c_q;
  assign blink_on    = b_q;
  assign shift_ofs   = ofs_q;
  assign cmd_vld     = vld_q;
  assign cmd_code    = code_q;
  assign overrun     = ovr_q;
  assign addr_err    = aerr_q;
  assign dbg_data    = dbg_q;

endmodule
`default_nettype wire

// File: doc/mfe_lcd1602_responder.md
# mfe_lcd1602_responder

HD44780-compatible responder for the 8-bit LCD1602 bus: the device end of the bus that `mfe_lcd1602_controller` drives. It decodes instructions and data writes, maintains an 80-byte DDRAM image, the address counter and the display flags, models the busy time, and answers busy-flag/AC and DDRAM reads. It is used as a synthesizable bus monitor and as the bench target for controller and demo verification. A debug port exposes the DDRAM image.

## Interface
- `BUSY_CYCLES`, default 1850: busy duration for ordinary instructions and data writes (37 us at 50 MHz).
- `CLEAR_CYCLES`, default 76000: busy duration for clear and home (1.52 ms at 50 MHz).
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `lcd_rs` in 1: register select (0 = instruction/status, 1 = data).
- `lcd_rw` in 1: 0 = write, 1 = read.
- `lcd_en` in 1: enable strobe, asynchronous to `clk`.
- `lcd_data_i` in 8: bus input.
- `lcd_data_o` out 8: read data.
- `lcd_data_oe` out 1: high while the responder drives the bus.
- `busy` out 1: busy flag.
- `ac` out 7: address counter.
- `disp_on`, `cursor_on`, `blink_on` out 1 each: display-control bits D, C, B.
- `shift_ofs` out 6: display shift offset, 0..39.
- `cmd_vld` out 1: one-cycle pulse per accepted transaction.
- `cmd_code` out 9: `{rs, data}` of the last accepted transaction.
- `overrun` out 1: sticky; set when a write arrives while busy.
- `addr_err` out 1: sticky; set when an invalid DDRAM address is written.
- `dbg_addr` in 7: DDRAM index, 0..79.
- `dbg_data` out 8: DDRAM[`dbg_addr`], registered.

## Operation
- **Bus sampling**
  - `lcd_en` passes through a 2-flop synchronizer plus one edge register. `lcd_rs`, `lcd_rw` and `lcd_data_i` are registered alongside it.
  - A transaction is the synchronized falling edge of `lcd_en`. The sampled rs/rw/data are those registered on the last cycle with en high.
- **Address mapping**
  - Valid AC values are 0x00–0x27 (line 0) and 0x40–0x67 (line 1).
  - DDRAM index = `ac[6]*40 + ac[5:0]`.
- **AC increment/decrement**
  - Direction is set by I/D (1 = increment).
  - Increment: 0x27 → 0x40, 0x67 → 0x00.
  - Decrement: 0x00 → 0x67, 0x40 → 0x27.
- **Data write (rs=1, rw=0)**
  - DDRAM[idx] ← data, then AC steps.
  - If S=1, `shift_ofs` also moves: +1 mod 40 when I/D=1, −1 mod 40 when I/D=0.
  - After a set-CGRAM instruction, data writes are accepted but discarded and AC does not step. Any DDRAM-address instruction returns to DDRAM mode.
- **Instruction write (rs=0, rw=0)**, decoded by the highest set bit:
  - 0x01 clear: fill DDRAM with 0x20 at one byte per cycle, AC←0, I/D←1, `shift_ofs`←0. Busy for `CLEAR_CYCLES`.
  - 0x02 home: AC←0, `shift_ofs`←0. Busy for `CLEAR_CYCLES`.
  - 0x04 entry mode: I/D←bit1, S←bit0.
  - 0x08 display control: D, C, B ← bits 2, 1, 0.
  - 0x10 shift: if bit3=0, step AC per bit2 (1 = right/increment). If bit3=1, step `shift_ofs` ±1 mod 40.
  - 0x20 function set: DL/N/F recorded, no other effect.
  - 0x40 set CGRAM address: enters CGRAM mode.
  - 0x80 set DDRAM address: AC←data[6:0]. An invalid value sets `addr_err` and forces AC to 0x00.
- **Reads (rw=1)**
  - `lcd_data_oe` = synchronized en & `lcd_rw`.
  - rs=0: `lcd_data_o` = `{busy, ac}`. Reading status is allowed while busy and does not set `overrun`.
  - rs=1: `lcd_data_o` = DDRAM[idx]; AC steps on the falling edge.
- **Busy handling**
  - Every accepted write loads the busy counter.
  - A write arriving while busy is ignored, sets `overrun`, and does not pulse `cmd_vld`.
- **Reset**
  - Outputs: AC=0, I/D=1, S=0, D=C=B=0, `shift_ofs`=0, flags=0, `cmd_vld`=0, `cmd_code`=0, `lcd_data_oe`=0, `lcd_data_o`=0, `dbg_data`=0.
  - `busy`=1 while an 80-cycle init sweep fills DDRAM with 0x20 after `rst` deasserts.
  - Reset during a sweep or busy period aborts it; the init sweep restarts on release.

## Timing
- **States:** INIT (80-cycle fill) → IDLE. IDLE → EXEC on a write. EXEC → CLRFILL for clear. CLRFILL → BUSY after 80 cycles. EXEC → BUSY otherwise. BUSY → IDLE when the counter reaches 0.
- **Busy timing**
  - `busy` asserts on the cycle after edge detection.
  - Busy lasts exactly `BUSY_CYCLES` cycles for ordinary writes, or `CLEAR_CYCLES` cycles for clear/home (clear's fill cycles are included).
- **Latencies**
  - Falling edge of `lcd_en` to `cmd_vld`: 3 clk.
  - `cmd_vld` and the AC/flag update happen in the same cycle.
  - `dbg_data`: 1 clk latency.
  - `lcd_data_o` is valid 3 clk after the rising edge of `lcd_en`.
- **Minimum strobe:** en high ≥ 3 clk and low ≥ 3 clk. Shorter pulses may be missed.

## Test plan
- Reset release: `busy`=1 for 80 cycles. Then `dbg_data`=0x20 for all indices 0..79, and AC=0.
- Controller writes "Make", 0xC0, "LCD": `dbg_addr` 0..3 = 0x4D, 0x61, 0x6B, 0x65; index 40..42 = 0x4C, 0x43, 0x44; `ac`=0x43.
- 0x80|0x27 followed by a data write of 0x41: index 39 = 0x41 and `ac`=0x40. Then 0x80|0x30: `addr_err`=1 and `ac`=0x00.
- Data write, then a status read at +2 clk: `lcd_data_o`=0x81 and `lcd_data_oe`=1. After `BUSY_CYCLES`, a status read returns 0x01.
- Write during busy: `overrun`=1, DDRAM unchanged, no `cmd_vld`.
- 0x01 after writing text: all indices read 0x20, `ac`=0, `busy` high for `CLEAR_CYCLES`. Then 0x06, 0x1C, 0x18: `shift_ofs` goes 1 → 0.
